// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared types and helpers for the fetch-PC generator.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Numeric order is the redirect priority.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_BR   = 2'd1,
        CLS_EXC  = 2'd2,
        CLS_DBG  = 2'd3
    } redir_cls_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    function automatic int fetch_bytes(input int fetch_width);
        return fetch_width * 4;
    endfunction

    function automatic int fetch_ofs(input int fetch_width);
        return $clog2(fetch_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_arb
// Purpose  : Fixed-priority pick among incoming redirects and the held one.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  enable,
    input  logic                  debug_valid,
    input  logic [ADDR_WIDTH-1:0] debug_pc,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  br_valid,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic [1:0]            pend_cls,
    input  logic [ADDR_WIDTH-1:0] pend_pc,
    output logic [1:0]            win_cls,
    output logic [ADDR_WIDTH-1:0] win_pc,
    output logic                  take,
    output logic                  latch
);

    redir_cls_e            w_in_cls;
    logic [ADDR_WIDTH-1:0] w_in_pc;
    logic                  w_in_wins;

    always_comb begin
        w_in_cls = CLS_NONE;
        w_in_pc  = br_pc;
        if (debug_valid) begin
            w_in_cls = CLS_DBG;
            w_in_pc  = debug_pc;
        end else if (exc_valid) begin
            w_in_cls = CLS_EXC;
            w_in_pc  = exc_pc;
        end else if (br_valid) begin
            w_in_cls = CLS_BR;
            w_in_pc  = br_pc;
        end
    end

    // A tie in class goes to the fresher incoming request.
    assign w_in_wins = (w_in_cls != CLS_NONE) && (w_in_cls >= redir_cls_e'(pend_cls));
    assign win_cls   = w_in_wins ? w_in_cls : pend_cls;
    assign win_pc    = w_in_wins ? w_in_pc  : pend_pc;
    assign take      = enable && (win_cls != CLS_NONE);
    assign latch     = !enable && w_in_wins;

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Block-aligned fetch-PC generator with prioritised redirects.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_pkg::*;
#(
    parameter int                  FETCH_WIDTH = 2,
    parameter int                  ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_INITIAL = ADDR_WIDTH'(32'hbfc00000)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   debug_reset,
    input  logic                   debug_valid,
    input  logic [ADDR_WIDTH-1:0]  debug_pc,
    input  logic                   exc_valid,
    input  logic [ADDR_WIDTH-1:0]  exc_pc,
    input  logic                   br_valid,
    input  logic [ADDR_WIDTH-1:0]  br_pc,
    input  logic                   halt_req,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [ADDR_WIDTH-1:0]  fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   fetch_addr_err,
    output logic                   fetch_flush,
    output logic                   redirect_pending
);

    localparam int c_ofs = fetch_ofs(FETCH_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_blk_bytes = ADDR_WIDTH'(fetch_bytes(FETCH_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] c_low_mask  = c_blk_bytes - 1'b1;

    pc_state_e             r_state,    w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, w_pc_nxt;
    redir_cls_e            r_pend_cls, w_pend_cls_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_pc,  w_pend_pc_nxt;
    logic                  r_flush,    w_flush_nxt;

    logic [1:0]            w_win_cls;
    logic [ADDR_WIDTH-1:0] w_win_pc;
    logic                  w_take;
    logic                  w_latch;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_seq_pc;

    pc_redirect_arb #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arb (
        .enable      (enable),
        .debug_valid (debug_valid),
        .debug_pc    (debug_pc),
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .pend_cls    (r_pend_cls),
        .pend_pc     (r_pend_pc),
        .win_cls     (w_win_cls),
        .win_pc      (w_win_pc),
        .take        (w_take),
        .latch       (w_latch)
    );

    // Next block boundary; wraps naturally at the top of the address space.
    assign w_seq_pc = (r_fetch_pc & ~c_low_mask) + c_blk_bytes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= PC_INITIAL;
            r_pend_cls <= CLS_NONE;
            r_pend_pc  <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_pend_cls <= w_pend_cls_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_flush    <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_fetch_pc;
        w_pend_cls_nxt = r_pend_cls;
        w_pend_pc_nxt  = r_pend_pc;
        w_flush_nxt    = 1'b0;
        if (debug_reset) begin
            w_state_nxt    = ST_BOOT;
            w_pc_nxt       = PC_INITIAL;
            w_pend_cls_nxt = CLS_NONE;
        end else if (!enable) begin
            if (w_latch) begin
                w_pend_cls_nxt = redir_cls_e'(w_win_cls);
                w_pend_pc_nxt  = w_win_pc;
            end
            if (r_state == ST_BOOT) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_take) begin
            w_pc_nxt       = w_win_pc;
            w_pend_cls_nxt = CLS_NONE;
            w_flush_nxt    = 1'b1;
            w_state_nxt    = ST_RUN;
        end else if (halt_req) begin
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_BOOT: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    // A misaligned block is never advanced past; park until redirected.
                    if (w_fire) begin
                        if (fetch_addr_err) begin
                            w_state_nxt = ST_HALT;
                        end else begin
                            w_pc_nxt = w_seq_pc;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        fetch_valid      = (r_state == ST_RUN) && enable;
        w_fire           = fetch_valid && fetch_ready;
        fetch_pc         = r_fetch_pc;
        fetch_addr_err   = |r_fetch_pc[1:0];
        fetch_flush      = r_flush;
        redirect_pending = (r_pend_cls != CLS_NONE);
    end

    generate
        if (c_ofs == 0) begin : g_mask_single
            assign fetch_mask = {FETCH_WIDTH{~fetch_addr_err}};
        end else begin : g_mask_multi
            logic [c_ofs-1:0] w_slot;
            assign w_slot = r_fetch_pc[c_ofs+1:2];
            for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_bit
                assign fetch_mask[i] = !fetch_addr_err && (w_slot <= c_ofs'(i));
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Scoreboarded directed + random bench for pc_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int          FW  = 2;
    localparam logic [31:0] PC0 = 32'hbfc00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, debug_reset, debug_valid, exc_valid, br_valid;
    logic        halt_req, fetch_ready;
    logic [31:0] debug_pc, exc_pc, br_pc;
    logic        fetch_valid, fetch_addr_err, fetch_flush, redirect_pending;
    logic [31:0] fetch_pc;
    logic [FW-1:0] fetch_mask;

    pc_gen #(.FETCH_WIDTH(FW), .ADDR_WIDTH(32), .PC_INITIAL(PC0)) dut (
        .clk (clk), .rst (rst), .enable (enable), .debug_reset (debug_reset),
        .debug_valid (debug_valid), .debug_pc (debug_pc),
        .exc_valid (exc_valid), .exc_pc (exc_pc),
        .br_valid (br_valid), .br_pc (br_pc),
        .halt_req (halt_req), .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid), .fetch_pc (fetch_pc), .fetch_mask (fetch_mask),
        .fetch_addr_err (fetch_addr_err), .fetch_flush (fetch_flush),
        .redirect_pending (redirect_pending)
    );

    typedef struct {
        logic          valid, flush, pend, err;
        logic [31:0]   pc;
        logic [FW-1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: mode 0=booting, 1=running, 2=halted; pending class 0..3.
    bit          m_known = 0;
    int          m_mode, m_pcls;
    logic [31:0] m_pc, m_ppc;
    logic        m_flush;

    // Staged stimulus, applied at the next falling edge.
    logic        s_rst = 1, s_en = 0, s_dr = 0, s_dv = 0, s_ev = 0, s_bv = 0;
    logic        s_halt = 0, s_rdy = 1;
    logic [31:0] s_dpc = 0, s_epc = 0, s_bpc = 0;

    task automatic step();
        exp_t        e;
        int          inc;
        logic [31:0] inc_pc;
        @(negedge clk);
        rst = s_rst; enable = s_en; debug_reset = s_dr; halt_req = s_halt;
        fetch_ready = s_rdy; debug_valid = s_dv; exc_valid = s_ev; br_valid = s_bv;
        debug_pc = s_dpc; exc_pc = s_epc; br_pc = s_bpc;
        if (m_known) begin
            e.valid = (m_mode == 1) && enable;
            e.pc    = m_pc;
            e.err   = (m_pc % 4) != 0;
            e.flush = m_flush;
            e.pend  = m_pcls != 0;
            for (int i = 0; i < FW; i++)
                e.mask[i] = !e.err && (i >= int'((m_pc / 4) % FW));
            exp_q.push_back(e);
        end
        if (rst || debug_reset) begin
            m_known = 1; m_mode = 0; m_pc = PC0; m_pcls = 0; m_ppc = 0; m_flush = 0;
        end else if (m_known) begin
            inc = 0; inc_pc = 0;
            if (debug_valid)    begin inc = 3; inc_pc = debug_pc; end
            else if (exc_valid) begin inc = 2; inc_pc = exc_pc;   end
            else if (br_valid)  begin inc = 1; inc_pc = br_pc;    end
            m_flush = 0;
            if (!enable) begin
                if (inc != 0 && inc >= m_pcls) begin m_pcls = inc; m_ppc = inc_pc; end
                if (m_mode == 0) m_mode = 1;
            end else if (inc != 0 || m_pcls != 0) begin
                m_pc = (inc != 0 && inc >= m_pcls) ? inc_pc : m_ppc;
                m_pcls = 0; m_flush = 1; m_mode = 1;
            end else if (halt_req) begin
                m_mode = 2;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1 && fetch_ready) begin
                if (m_pc % 4 != 0) m_mode = 2;
                else m_pc = (m_pc / (4 * FW) + 1) * (4 * FW);
            end
        end
    endtask

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fetch_valid", 32'(fetch_valid), 32'(e.valid));
                chk("fetch_pc", fetch_pc, e.pc);
                chk("fetch_mask", 32'(fetch_mask), 32'(e.mask));
                chk("fetch_addr_err", 32'(fetch_addr_err), 32'(e.err));
                chk("fetch_flush", 32'(fetch_flush), 32'(e.flush));
                chk("redirect_pending", 32'(redirect_pending), 32'(e.pend));
            end
        end
    end

    function automatic logic [31:0] rnd_pc();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    task automatic clr_redir();
        s_dv = 0; s_ev = 0; s_bv = 0;
    endtask

    initial begin : driver
        rst = 1; enable = 0; debug_reset = 0; debug_valid = 0; exc_valid = 0;
        br_valid = 0; halt_req = 0; fetch_ready = 1; debug_pc = 0; exc_pc = 0; br_pc = 0;
        step(); step();
        // Boot and sequential fetch
        s_rst = 0; s_en = 1; s_rdy = 1;
        repeat (4) step();
        // Branch into the middle of a block
        s_bv = 1; s_bpc = 32'hbfc00014; step(); clr_redir(); repeat (3) step();
        // Stalled branch then exception; exception must win on release
        s_en = 0; s_bv = 1; s_bpc = 32'h80001000; step(); clr_redir();
        s_ev = 1; s_epc = 32'hbfc00380; step(); clr_redir(); step();
        s_en = 1; repeat (2) step();
        // Lone stalled branch
        s_en = 0; s_bv = 1; s_bpc = 32'h80001000; step(); clr_redir(); step();
        s_en = 1; repeat (2) step();
        // Simultaneous exception and branch
        s_ev = 1; s_epc = 32'hbfc00380; s_bv = 1; s_bpc = 32'h80000000; step();
        clr_redir(); step();
        // Misaligned target parks in HALT, aligned redirect recovers
        s_bv = 1; s_bpc = 32'h80000002; step(); clr_redir(); repeat (3) step();
        s_bv = 1; s_bpc = 32'h80000000; step(); clr_redir(); repeat (2) step();
        // Back-pressure
        s_rdy = 0; repeat (3) step(); s_rdy = 1; step();
        // Halt request, then redirect out of HALT
        s_halt = 1; step(); s_halt = 0; repeat (2) step();
        s_bv = 1; s_bpc = 32'h80000100; step(); clr_redir(); step();
        // Debug reset while a redirect is pending
        s_en = 0; s_bv = 1; s_bpc = 32'h80002000; step();
        s_dr = 1; s_ev = 1; s_epc = 32'h12345678; step(); clr_redir();
        s_dr = 0; s_en = 1; repeat (3) step();
        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            s_rst  = ($urandom_range(0, 199) == 0);
            s_dr   = ($urandom_range(0, 99) == 0);
            s_en   = ($urandom_range(0, 9) < 8);
            s_rdy  = ($urandom_range(0, 9) < 7);
            s_halt = ($urandom_range(0, 29) == 0);
            s_dv   = ($urandom_range(0, 29) == 0);
            s_ev   = ($urandom_range(0, 14) == 0);
            s_bv   = ($urandom_range(0, 7) == 0);
            s_dpc  = rnd_pc(); s_epc = rnd_pc(); s_bpc = rnd_pc();
            step();
        end
        s_rst = 0; s_dr = 0; s_halt = 0; s_en = 1; clr_redir();
        repeat (3) step();
        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
